// File: rtl/branch_lut_rw.sv
// branch_lut_rw: writable signed-offset lookup table with init walker and PC-relative target
module branch_lut_rw #(
  parameter int IDX_W = 4,
  parameter int DATA_W = 10,
  parameter int PC_W = 12,
  parameter logic signed [DATA_W-1:0] DEFAULT0 = -408,
  parameter logic signed [DATA_W-1:0] DEFAULT_N = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RdEn,
  input  logic [IDX_W-1:0]  RdIdx,
  input  logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] RdData,
  output logic [PC_W-1:0]   Target,
  output logic              RdValid,
  input  logic              WrEn,
  input  logic [IDX_W-1:0]  WrIdx,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrErr,
  output logic              Busy
);
  localparam int DEPTH = 2**IDX_W;
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [IDX_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_val;
  logic rd_ok, wr_ok;
  // accept only when ready; a same-index write in the same cycle bypasses into the read
  always_comb begin
    rd_ok = RdEn && state == READY;
    wr_ok = WrEn && state == READY;
    rd_val = (wr_ok && WrIdx == RdIdx) ? WrData : mem[RdIdx];
  end
  // init walker FSM plus registered read result and write-drop flag
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= INIT;
      cnt <= '0;
      Busy <= 1'b1;
      RdData <= '0;
      Target <= '0;
      RdValid <= 1'b0;
      WrErr <= 1'b0;
    end else begin
      RdValid <= rd_ok;
      WrErr <= WrEn && state == INIT;
      if (rd_ok) begin
        RdData <= rd_val;
        Target <= PC + PC_W'($signed(rd_val));
      end
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state <= READY;
          Busy <= 1'b0;
        end
      end
    end
  // table storage: walker owns it during init, software writes afterwards
  always_ff @(posedge Clk)
    if (state == INIT) mem[cnt] <= (cnt == '0) ? DEFAULT0 : DEFAULT_N;
    else if (wr_ok) mem[WrIdx] <= WrData;
endmodule

// File: tb/tb_branch_lut_rw.sv
// tb_branch_lut_rw: randomized scoreboard bench for branch_lut_rw against a cycle-count reference model
module tb_branch_lut_rw;
  logic clk = 0, reset = 1;
  logic rden = 0, wren = 0;
  logic [3:0] rdidx = 0, wridx = 0;
  logic [11:0] pc = 0;
  logic [9:0] wrdata = 0;
  logic [9:0] rddata;
  logic [11:0] target;
  logic rdvalid, wrerr, busy;
  int checks = 0, errors = 0;

  typedef struct {logic [9:0] d; logic [11:0] t;} rd_t;
  rd_t q[$];
  logic [9:0] mm [16];
  int cyc = 0;
  bit exp_busy = 1, exp_wrerr = 0, exp_rv = 0;
  logic [9:0] hold_d = 0;
  logic [11:0] hold_t = 0;

  branch_lut_rw dut (
    .Clk(clk), .Reset(reset), .RdEn(rden), .RdIdx(rdidx), .PC(pc),
    .RdData(rddata), .Target(target), .RdValid(rdvalid),
    .WrEn(wren), .WrIdx(wridx), .WrData(wrdata), .WrErr(wrerr), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: the table is usable once 16 clean cycles have elapsed since reset release
  always @(posedge clk) begin
    bit ready;
    int off;
    logic [9:0] v;
    if (reset) begin
      cyc = 0;
      for (int i = 0; i < 16; i++) mm[i] = (i == 0) ? 10'h268 : 10'd1;
      exp_busy = 1;
      exp_wrerr = 0;
      exp_rv = 0;
      q.delete();
    end else begin
      ready = cyc >= 16;
      exp_wrerr = wren && !ready;
      exp_rv = rden && ready;
      if (exp_rv) begin
        v = (wren && wridx == rdidx) ? wrdata : mm[rdidx];
        off = int'(v);
        if (off >= 512) off -= 1024;
        q.push_back('{v, 12'((int'(pc) + off) & 4095)});
      end
      if (wren && ready) mm[wridx] = wrdata;
      if (cyc < 16) cyc++;
      exp_busy = cyc < 16;
    end
  end

  // monitor: compares flags every cycle and pops the scoreboard on each RdValid
  always @(posedge clk) begin
    rd_t e;
    #1;
    chk("busy", busy, exp_busy);
    chk("wrerr", wrerr, exp_wrerr);
    chk("rdvalid", rdvalid, exp_rv);
    if (reset) begin
      hold_d = 0;
      hold_t = 0;
    end
    if (rdvalid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got rdvalid=1 want no pending read at %0t", $time);
      end else begin
        e = q.pop_front();
        hold_d = e.d;
        hold_t = e.t;
      end
    end
    chk("rddata", rddata, hold_d);
    chk("target", target, hold_t);
  end

  task automatic step(input bit rs, input bit re, input logic [3:0] ri, input logic [11:0] p,
                      input bit we, input logic [3:0] wi, input logic [9:0] wd);
    @(negedge clk);
    reset = rs;
    rden = re;
    rdidx = ri;
    pc = p;
    wren = we;
    wridx = wi;
    wrdata = wd;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    idle();
    n = 0;
    repeat (20) begin
      if (busy) n++;
      @(negedge clk);
    end
    chk("busy_len", n, 16);
    step(0, 1, 0, 500, 0, 0, 0);
    idle();
    chk("rd0_data", rddata, 10'h268);
    chk("rd0_target", target, 92);
    chk("rd0_valid", rdvalid, 1);
    idle();
    chk("rd0_pulse", rdvalid, 0);
    step(0, 1, 7, 12'hFFF, 0, 0, 0);
    idle();
    chk("rd7_data", rddata, 1);
    chk("rd7_wrap", target, 0);
    step(0, 0, 0, 0, 1, 3, 10'h3FF);
    step(0, 1, 3, 10, 0, 0, 0);
    idle();
    chk("wr3_data", rddata, 10'h3FF);
    chk("wr3_target", target, 9);
    step(0, 1, 5, 0, 1, 5, 10'h1FF);
    idle();
    chk("bypass_data", rddata, 10'h1FF);
    chk("bypass_target", target, 511);
    step(0, 0, 0, 0, 1, 0, 10'h055);
    step(0, 0, 0, 0, 1, 9, 10'h077);
    step(1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("reset_rddata", rddata, 0);
    chk("reset_busy", busy, 1);
    repeat (3) idle();
    step(0, 0, 0, 0, 1, 9, 10'd77);
    idle();
    chk("init_wrerr", wrerr, 1);
    idle();
    chk("init_wrerr_pulse", wrerr, 0);
    repeat (14) idle();
    step(0, 1, 9, 100, 0, 0, 0);
    idle();
    chk("reload9_data", rddata, 1);
    chk("reload9_target", target, 101);
    step(0, 1, 0, 1000, 0, 0, 0);
    idle();
    chk("reload0_data", rddata, 10'h268);
    chk("reload0_target", target, 592);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) chk("sweep_valid", rdvalid, 1);
      reset = 0;
      wren = 0;
      rden = i < 16;
      rdidx = 4'(i);
      pc = 12'($urandom);
    end
    idle();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        repeat ($urandom_range(3, 1)) step(1, $urandom, 4'($urandom), 12'($urandom), $urandom, 4'($urandom), 10'($urandom));
      end
      step(0, $urandom, 4'($urandom), 12'($urandom), $urandom_range(3) == 0, 4'($urandom), 10'($urandom));
    end
    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
